// File: rtl/prog_lut_unit_pkg.sv
// Shared types and sizing helpers for the programmable LUT unit.
package lut_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_LOAD
    } lut_state_e;

    function automatic int unsigned lut_total(input int unsigned in_w, input int unsigned out_w);
        return out_w * (32'd1 << in_w);
    endfunction

    // One extra bit so the counter can represent TOTAL itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned total);
        return $clog2(total) + 1;
    endfunction

endpackage

// File: rtl/prog_lut_unit_if.sv
// Configuration and evaluation signals of the programmable LUT unit.
interface prog_lut_unit_if #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 1
);
    logic             cfg_start;
    logic             cfg_valid;
    logic             cfg_bit;
    logic             cfg_busy;
    logic             cfg_done;
    logic             in_valid;
    logic [IN_W-1:0]  x;
    logic             out_valid;
    logic [OUT_W-1:0] y;

    modport master (
        output cfg_start, cfg_valid, cfg_bit, in_valid, x,
        input  cfg_busy, cfg_done, out_valid, y
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, in_valid, x,
        output cfg_busy, cfg_done, out_valid, y
    );
endinterface

// File: rtl/prog_lut_unit_mux.sv
// Parametrised 2**SEL_W:1 combinational mux; one instance per LUT output channel.
module lut_mux #(
    parameter int SEL_W = 5
) (
    input  logic [(2**SEL_W)-1:0] data,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out
);
    assign out = data[sel];
endmodule

// File: rtl/prog_lut_unit.sv
// Runtime-programmable multi-output LUT with serial shadow load and atomic commit.
// Build option: LUT_INIT_EN makes reset load both tables from INIT instead of zero.
module prog_lut_unit
    import lut_pkg::*;
#(
    parameter int                           IN_W  = 5,
    parameter int                           OUT_W = 1,
    parameter logic [OUT_W*(2**IN_W)-1:0]   INIT  = '0
) (
    input  logic            clk,
    input  logic            rst,
    prog_lut_unit_if.slave  bus
);
    localparam int unsigned TBL   = 2**IN_W;
    localparam int unsigned TOTAL = lut_total(IN_W, OUT_W);
    localparam int unsigned CW    = cnt_width(TOTAL);
    localparam int unsigned IW    = $clog2(TOTAL);

`ifdef LUT_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam logic [TOTAL-1:0] RST_IMG = INIT_EN ? INIT : '0;

    lut_state_e       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [TOTAL-1:0] shadow, shadow_nxt;
    logic [TOTAL-1:0] active;
    logic             commit;
    logic             done_q;
    logic             ov_q;
    logic [OUT_W-1:0] y_q, y_mux;
    logic [IW-1:0]    idx;

    assign idx = cnt[IW-1:0];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (bus.cfg_start) begin
                    cnt_nxt = '0;
                end else if (bus.cfg_valid) begin
                    shadow_nxt[idx] = bus.cfg_bit;
                    // Commit copies the merged image so the final bit lands in the same edge.
                    if (cnt == CW'(TOTAL - 1)) begin
                        commit    = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            shadow <= RST_IMG;
            active <= RST_IMG;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            done_q <= commit;
            if (commit) begin
                active <= shadow_nxt;
            end
        end
    end

    for (genvar k = 0; k < OUT_W; k++) begin : g_ch
        lut_mux #(.SEL_W(IN_W)) u_mux (
            .data (active[k*TBL +: TBL]),
            .sel  (bus.x),
            .out  (y_mux[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q <= 1'b0;
            y_q  <= '0;
        end else begin
            ov_q <= bus.in_valid;
            if (bus.in_valid) begin
                y_q <= y_mux;
            end
        end
    end

    assign bus.cfg_busy  = (state == ST_LOAD);
    assign bus.cfg_done  = done_q;
    assign bus.out_valid = ov_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_prog_lut_unit.sv
// Self-checking bench for prog_lut_unit: table vectors, corner sequences and random traffic.
module tb_prog_lut_unit;
    localparam logic [31:0] INIT_A = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_lut_unit_if #(.IN_W(5), .OUT_W(1)) ifa ();
    prog_lut_unit_if #(.IN_W(2), .OUT_W(2)) ifb ();

    prog_lut_unit #(.IN_W(5), .OUT_W(1), .INIT(INIT_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    prog_lut_unit #(.IN_W(2), .OUT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct packed {
        logic [4:0] x;
        logic       y;
    } vec_a_t;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
    } vec_b_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned done_seen = 0;

    // Reference model: a table, a queue of collected bits and a loading flag.
    bit          ref_tbl[32];
    bit          ref_q[$];
    bit          ref_loading;
    logic        ref_y;
    logic [31:0] rst_img;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_loading = 1'b0;
        ref_q.delete();
        ref_y = 1'b0;
        for (int i = 0; i < 32; i++) ref_tbl[i] = rst_img[i];
    endtask

    task automatic tick_a(input bit start, input bit valid, input bit b, input bit iv, input logic [4:0] xv);
        bit exp_done;
        ifa.cfg_start = start;
        ifa.cfg_valid = valid;
        ifa.cfg_bit   = b;
        ifa.in_valid  = iv;
        ifa.x         = xv;
        exp_done = 1'b0;
        if (iv) ref_y = ref_tbl[xv];
        if (start) begin
            ref_loading = 1'b1;
            ref_q.delete();
        end else if (ref_loading && valid) begin
            ref_q.push_back(b);
            if (ref_q.size() == 32) begin
                for (int i = 0; i < 32; i++) ref_tbl[i] = ref_q[i];
                ref_loading = 1'b0;
                exp_done    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (ifa.cfg_done === 1'b1) done_seen++;
        check("a_out_valid", ifa.out_valid, iv);
        check("a_y",         ifa.y,         ref_y);
        check("a_cfg_done",  ifa.cfg_done,  exp_done);
        check("a_cfg_busy",  ifa.cfg_busy,  ref_loading);
    endtask

    task automatic load_a(input logic [31:0] word, input bit iv, input logic [4:0] xv);
        tick_a(1'b1, 1'b0, 1'b0, iv, xv);
        for (int i = 0; i < 32; i++) tick_a(1'b0, 1'b1, word[i], iv, xv);
    endtask

    task automatic tick_b(input bit start, input bit valid, input bit b, input bit iv, input logic [1:0] xv);
        ifb.cfg_start = start;
        ifb.cfg_valid = valid;
        ifb.cfg_bit   = b;
        ifb.in_valid  = iv;
        ifb.x         = xv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_a_t      va[6];
        vec_b_t      vb[4];
        logic [7:0]  b_img;
        int unsigned done_before;

        va[0] = '{x: 5'd0,  y: 1'b1};
        va[1] = '{x: 5'd5,  y: 1'b1};
        va[2] = '{x: 5'd6,  y: 1'b0};
        va[3] = '{x: 5'd1,  y: 1'b0};
        va[4] = '{x: 5'd31, y: 1'b0};
        va[5] = '{x: 5'd4,  y: 1'b0};
        vb[0] = '{x: 2'd0, y: 2'b00};
        vb[1] = '{x: 2'd1, y: 2'b01};
        vb[2] = '{x: 2'd2, y: 2'b01};
        vb[3] = '{x: 2'd3, y: 2'b10};
        b_img = 8'b1000_0110;

`ifdef LUT_INIT_EN
        rst_img = INIT_A;
`else
        rst_img = 32'h0;
`endif

        rst = 1'b1;
        ifa.cfg_start = 1'b0; ifa.cfg_valid = 1'b0; ifa.cfg_bit = 1'b0; ifa.in_valid = 1'b0; ifa.x = '0;
        ifb.cfg_start = 1'b0; ifb.cfg_valid = 1'b0; ifb.cfg_bit = 1'b0; ifb.in_valid = 1'b0; ifb.x = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_busy", ifa.cfg_busy, 1'b0);
        check("rst_a_done", ifa.cfg_done, 1'b0);
        check("rst_a_ov",   ifa.out_valid, 1'b0);
        check("rst_a_y",    ifa.y, 1'b0);
        check("rst_b_ov",   ifb.out_valid, 1'b0);
        check("rst_b_y",    ifb.y, 2'b00);
        rst = 1'b0;

        // Sweep of the reset table, then cfg_valid outside a load must be ignored.
        for (int i = 0; i < 32; i++) tick_a(1'b0, 1'b0, 1'b0, 1'b1, 5'(i));
        check("init_x31", ifa.y, rst_img[31]);
        for (int i = 0; i < 3; i++) tick_a(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);

        load_a(32'h0000_0021, 1'b0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            tick_a(1'b0, 1'b0, 1'b0, 1'b1, va[i].x);
            check("tbl_21", ifa.y, va[i].y);
        end

        // Evaluation during a load and in the commit cycle sees the old table.
        load_a(32'h0, 1'b1, 5'd5);
        check("commit_cycle_old", ifa.y, 1'b1);
        tick_a(1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        check("after_commit_new", ifa.y, 1'b0);

        // Restart mid-load; the restart cycle also carries cfg_valid, which must be dropped.
        done_before = done_seen;
        tick_a(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) tick_a(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        tick_a(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) tick_a(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
        check("restart_single_done", done_seen - done_before, 1);
        for (int i = 0; i < 32; i++) begin
            tick_a(1'b0, 1'b0, 1'b0, 1'b1, 5'(i));
            check("ones_tbl", ifa.y, 1'b1);
        end

        for (int n = 0; n < 600; n++) begin
            tick_a(($urandom_range(59) == 0), ($urandom_range(3) != 0), 1'($urandom),
                   1'($urandom), 5'($urandom));
        end
        tick_a(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Two-channel instance: XOR on channel 0, AND on channel 1.
        tick_b(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        check("b_busy", ifb.cfg_busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick_b(1'b0, 1'b1, b_img[i], 1'b0, 2'd0);
            check("b_done", ifb.cfg_done, (i == 7));
        end
        tick_b(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("b_done_pulse", ifb.cfg_done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick_b(1'b0, 1'b0, 1'b0, 1'b1, vb[i].x);
            check("b_tbl", ifb.y, vb[i].y);
            check("b_ov", ifb.out_valid, 1'b1);
        end

        // Reset in the middle of a load aborts it and restores the reset table.
        tick_a(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) tick_a(1'b0, 1'b1, 1'b0, 1'b1, 5'd31);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", ifa.cfg_busy, 1'b0);
        check("mid_rst_ov",   ifa.out_valid, 1'b0);
        check("mid_rst_y",    ifa.y, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick_a(1'b0, 1'b0, 1'b0, 1'b1, 5'd31);
        check("mid_rst_x31", ifa.y, rst_img[31]);
        tick_a(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
